// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// gate_op_arbiter : round-robin arbiter sharing one registered bitwise-op unit
//                   between two requesters; optional GATE_ARB_STATS_EN adds
//                   saturating per-requester grant counters.
// Revision: 1.0
// ============================================================================
module gate_op_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [WIDTH-1:0] res,
  output logic             res_id,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    apply_op = ~a;
      3'd1:    apply_op = a & b;
      3'd2:    apply_op = a | b;
      3'd3:    apply_op = ~(a & b);
      3'd4:    apply_op = a ^ b;
      3'd5:    apply_op = ~(a | b);
      3'd6:    apply_op = ~(a ^ b);
      default: apply_op = '0;
    endcase
  endfunction

  logic [WIDTH-1:0] res_q, res_d;
  logic             res_id_q, res_id_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;
  logic             rr_ptr_q, rr_ptr_d;
  // Set after the first grant; until then req0 wins a conflict.
  logic             any_gnt_q, any_gnt_d;
  logic             stall;

  always_comb begin
    stall = res_valid_q && !res_ready;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!rst && !stall) begin
      if (req0 && req1) begin
        if (any_gnt_q && !rr_ptr_q) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    rr_ptr_d    = rr_ptr_q;
    any_gnt_d   = any_gnt_q;
    if (gnt0) begin
      res_d       = apply_op(op0, a0, b0);
      res_id_d    = 1'b0;
      res_err_d   = (op0 == OP_ILLEGAL);
      res_valid_d = 1'b1;
      rr_ptr_d    = 1'b0;
      any_gnt_d   = 1'b1;
    end else if (gnt1) begin
      res_d       = apply_op(op1, a1, b1);
      res_id_d    = 1'b1;
      res_err_d   = (op1 == OP_ILLEGAL);
      res_valid_d = 1'b1;
      rr_ptr_d    = 1'b1;
      any_gnt_d   = 1'b1;
    end else if (!stall) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      any_gnt_q   <= 1'b0;
    end else begin
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      any_gnt_q   <= any_gnt_d;
    end
  end

  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;

`ifdef GATE_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (gnt1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = 16'h0000;
  assign cnt1 = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// tb_gate_op_arbiter : directed scoreboard bench for gate_op_arbiter (WIDTH=8).
// Revision: 1.0
// ============================================================================
module tb_gate_op_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, req0, req1, res_ready;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, res_id, res_err, res_valid;
  logic [W-1:0] res;
  logic [15:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  gate_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res(res), .res_id(res_id), .res_err(res_err), .res_valid(res_valid),
    .res_ready(res_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         id;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic exp_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=res %0h id %0d required=no pending result", res, res_id);
        end else begin
          mon_e = sb.pop_front();
          chk("res",     32'(res),     32'(mon_e.res));
          chk("res_id",  32'(res_id),  32'(mon_e.id));
          chk("res_err", 32'(res_err), 32'(mon_e.err));
        end
      end
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic r0, input logic [2:0] o0, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                      input logic r1, input logic [2:0] o1, input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                      input logic rdy, input logic eg0, input logic eg1, input logic [W-1:0] eres);
    exp_t e;
    req0 = r0; op0 = o0; a0 = xa0; b0 = xb0;
    req1 = r1; op1 = o1; a1 = xa1; b1 = xb1;
    res_ready = rdy;
    @(negedge clk);
    #1;
    chk("gnt0",      32'(gnt0),      32'(eg0));
    chk("gnt1",      32'(gnt1),      32'(eg1));
    chk("res_valid", 32'(res_valid), 32'(exp_valid));
    if (eg0 || eg1) begin
      e.res = eres;
      e.id  = eg1;
      e.err = ((eg0 ? o0 : o1) == 3'd7);
      sb.push_back(e);
    end
    exp_valid = (eg0 || eg1) ? 1'b1 : (exp_valid && !rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Requests are held high in the first reset cycle to prove grants are masked.
  task automatic do_reset();
    rst = 1'b1; res_ready = 1'b0;
    req0 = 1'b1; op0 = 3'd1; a0 = 8'hFF; b0 = 8'hFF;
    req1 = 1'b1; op1 = 3'd1; a1 = 8'hFF; b1 = 8'hFF;
    @(negedge clk);
    #1;
    chk("gnt0_in_rst", 32'(gnt0), 32'(1'b0));
    chk("gnt1_in_rst", 32'(gnt1), 32'(1'b0));
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; res_ready = 1'b1; exp_valid = 1'b0;
  endtask

  initial begin
    exp_valid = 1'b0;
    do_reset();
    chk("rst_res",       32'(res),       32'(8'h00));
    chk("rst_res_id",    32'(res_id),    32'(1'b0));
    chk("rst_res_err",   32'(res_err),   32'(1'b0));
    chk("rst_res_valid", 32'(res_valid), 32'(1'b0));
    chk("rst_cnt0",      32'(cnt0),      32'(16'h0000));
    chk("rst_cnt1",      32'(cnt1),      32'(16'h0000));

    // Opcode sweep on requester 0 with all-ones operands.
    step(1, 3'd0, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h00);
    step(1, 3'd1, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'hFF);
    step(1, 3'd2, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'hFF);
    step(1, 3'd3, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h00);
    step(1, 3'd4, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h00);
    step(1, 3'd5, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h00);
    step(1, 3'd6, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'hFF);
    idle();
    idle();

    // Grant a result that is never consumed, then reset: it must be discarded.
    step(1, 3'd1, 8'hFF, 8'hFF, 0, 3'd0, 8'h00, 8'h00, 0, 1, 0, 8'hFF);
    do_reset();
    chk("rst_discard_valid", 32'(res_valid), 32'(1'b0));

    // Both requesting from reset: strict alternation starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(1, 3'd1, 8'hF0, 8'h3C, 1, 3'd2, 8'hF0, 8'h0F, 1, 1, 0, 8'h30);
      else
        step(1, 3'd1, 8'hF0, 8'h3C, 1, 3'd2, 8'hF0, 8'h0F, 1, 0, 1, 8'hFF);
    end
    idle();

    // Backpressure: result held, req1 blocked, then granted on the release cycle.
    step(1, 3'd1, 8'hF0, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h30);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 8'h00, 8'h00, 1, 3'd2, 8'hF0, 8'h0F, 0, 0, 0, 8'h00);
      chk("res_hold", 32'(res), 32'(8'h30));
    end
    step(0, 3'd0, 8'h00, 8'h00, 1, 3'd2, 8'hF0, 8'h0F, 1, 0, 1, 8'hFF);
    idle();

    // Illegal opcode, then a legal op clears the error flag.
    step(0, 3'd0, 8'h00, 8'h00, 1, 3'd7, 8'hFF, 8'hFF, 1, 0, 1, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 1, 3'd4, 8'hFF, 8'h0F, 1, 0, 1, 8'hF0);
    idle();

    // Wide operands and grant counting from a fresh reset.
    do_reset();
    step(1, 3'd4, 8'hF0, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'hCC);
    step(1, 3'd3, 8'hF0, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'hCF);
    step(1, 3'd1, 8'hF0, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h30);
    idle();
`ifdef GATE_ARB_STATS_EN
    chk("cnt0_three", 32'(cnt0), 32'(16'd3));
    chk("cnt1_zero",  32'(cnt1), 32'(16'd0));
    for (int i = 0; i < 65533; i++)
      step(1, 3'd0, 8'hF0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h0F);
    idle();
    chk("cnt0_at_max", 32'(cnt0), 32'(16'hFFFF));
    step(1, 3'd0, 8'hF0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h0F);
    step(1, 3'd0, 8'hF0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1, 1, 0, 8'h0F);
    idle();
    chk("cnt0_saturated", 32'(cnt0), 32'(16'hFFFF));
`else
    chk("cnt0_tied", 32'(cnt0), 32'(16'h0000));
    chk("cnt1_tied", 32'(cnt1), 32'(16'h0000));
`endif

    idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
